// File: rtl/disk_dma_pkg.sv
// Shared types and constants for the DMA-bridge disk responder.
// Register offsets are word indices taken from mem_address[9:2].
package disk_dma_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 8;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [OFF_W-1:0] REG_STATUS = 8'h80;
    localparam logic [OFF_W-1:0] REG_LBA    = 8'h81;
    localparam logic [OFF_W-1:0] REG_RESULT = 8'h82;

    localparam int unsigned RESULT_OK_BIT  = 0;
    localparam int unsigned RESULT_ERR_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Command captured from the controller when an operation starts.
    typedef struct packed {
        logic              write;
        logic              device;
        logic [DATA_W-1:0] lba;
    } op_cmd_t;

endpackage

// File: rtl/sector_ram.sv
// Single-port word RAM with byte lanes and a one-cycle registered read.
// Only the read register is reset; the array contents are not.
module sector_ram
    import disk_dma_pkg::*;
#(
    parameter int unsigned WORDS = 128,
    localparam int unsigned AW   = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] wmask_c;

    always_comb begin
        wmask_c = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= (mem[addr] & ~wmask_c) | (wdata & wmask_c);
        end
    end

    // Read samples the array before this cycle's write lands: old data on collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/disk_dma_responder.sv
// Avalon-MM responder for the HPS DMA bridge: sector buffer, command/status
// registers and the disk request handshake toward the HPS.
module disk_dma_responder
    import disk_dma_pkg::*;
#(
    parameter int unsigned BUF_WORDS = 128,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            mem_address,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [DATA_W-1:0]            mem_writedata,
    input  logic [BE_W-1:0]              mem_byteenable,
    output logic                         mem_waitrequest,
    output logic [DATA_W-1:0]            mem_readdata,
    output logic                         mem_readdatavalid,
    input  logic [$clog2(BUF_WORDS)-1:0] buf_addr,
    input  logic                         buf_we,
    input  logic                         buf_re,
    input  logic [DATA_W-1:0]            buf_wdata,
    output logic [DATA_W-1:0]            buf_rdata,
    input  logic                         op_req,
    input  logic                         op_write,
    input  logic                         op_device,
    input  logic [DATA_W-1:0]            op_lba,
    output logic                         op_done,
    output logic                         op_error,
    output logic                         disk_op_read,
    output logic                         disk_op_write,
    output logic                         disk_op_device
);

    localparam int unsigned AW = $clog2(BUF_WORDS);
    localparam int unsigned PW = RD_LAT * DATA_W;

    logic             wait_q;
    logic [OFF_W-1:0] reg_off_c;
    logic             buf_hit_c;
    logic             mem_req_c;
    logic             int_act_c;
    logic             stall_c;
    logic             accept_c;
    logic             acc_rd_c;
    logic             acc_wr_c;
    logic             unused_addr;

    assign reg_off_c   = mem_address[9:2];
    assign buf_hit_c   = ~mem_address[9];
    assign mem_req_c   = mem_read | mem_write;
    assign int_act_c   = buf_we | buf_re;
    assign unused_addr = ^{mem_address[DATA_W-1:10], mem_address[1:0]};

    // Internal port wins the RAM; only buffer-space requests can be stalled.
    assign stall_c         = int_act_c & mem_req_c & buf_hit_c;
    assign mem_waitrequest = reset | wait_q | stall_c;
    assign accept_c        = mem_req_c & ~mem_waitrequest;
    assign acc_wr_c        = accept_c & mem_write;
    assign acc_rd_c        = accept_c & mem_read & ~mem_write;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wait_q <= 1'b1;
        end else begin
            wait_q <= 1'b0;
        end
    end

    // ---------------- sector buffer arbitration ----------------
    logic              ram_en_c;
    logic              ram_we_c;
    logic [BE_W-1:0]   ram_be_c;
    logic [AW-1:0]     ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic [DATA_W-1:0] ram_q;

    always_comb begin
        ram_en_c    = 1'b0;
        ram_we_c    = 1'b0;
        ram_be_c    = '0;
        ram_addr_c  = mem_address[AW+1:2];
        ram_wdata_c = mem_writedata;
        if (int_act_c) begin
            ram_en_c    = 1'b1;
            ram_we_c    = buf_we;
            ram_be_c    = '1;
            ram_addr_c  = buf_addr;
            ram_wdata_c = buf_wdata;
        end else if (accept_c && buf_hit_c) begin
            ram_en_c = 1'b1;
            ram_we_c = acc_wr_c;
            ram_be_c = mem_byteenable;
        end
    end

    sector_ram #(
        .WORDS (BUF_WORDS)
    ) u_sector_ram (
        .clk   (clk_sys),
        .reset (reset),
        .en    (ram_en_c),
        .we    (ram_we_c),
        .be    (ram_be_c),
        .addr  (ram_addr_c),
        .wdata (ram_wdata_c),
        .q     (ram_q)
    );

    assign buf_rdata = ram_q;

    // ---------------- command FSM ----------------
    state_t            state_q;
    state_t            state_d;
    op_cmd_t           cmd_q;
    op_cmd_t           cmd_d;
    logic              done_d;
    logic              err_d;
    logic              result_wr_c;
    logic              res_ok_c;
    logic              res_err_c;
    logic [DATA_W-1:0] reg_rdata_c;

    assign result_wr_c = acc_wr_c & (reg_off_c == REG_RESULT);
    assign res_ok_c    = mem_writedata[RESULT_OK_BIT];
    assign res_err_c   = mem_writedata[RESULT_ERR_BIT];

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        done_d  = 1'b0;
        err_d   = op_error;
        case (state_q)
            IDLE: begin
                if (op_req) begin
                    cmd_d.write  = op_write;
                    cmd_d.device = op_device;
                    cmd_d.lba    = op_lba;
                    err_d        = 1'b0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                // A RESULT write with no bit set is not a completion.
                if (result_wr_c && (res_ok_c || res_err_c)) begin
                    done_d  = 1'b1;
                    err_d   = res_err_c;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= IDLE;
            cmd_q          <= '0;
            op_done        <= 1'b0;
            op_error       <= 1'b0;
            disk_op_read   <= 1'b0;
            disk_op_write  <= 1'b0;
            disk_op_device <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            op_done        <= done_d;
            op_error       <= err_d;
            disk_op_read   <= (state_d == REQ) & ~cmd_d.write;
            disk_op_write  <= (state_d == REQ) & cmd_d.write;
            disk_op_device <= (state_d == REQ) & cmd_d.device;
        end
    end

    always_comb begin
        reg_rdata_c = '0;
        case (reg_off_c)
            REG_STATUS: reg_rdata_c = {29'b0, (state_q == REQ), cmd_q.device, cmd_q.write};
            REG_LBA:    reg_rdata_c = cmd_q.lba;
            default:    reg_rdata_c = '0;
        endcase
    end

    // ---------------- read return pipe ----------------
    // Stage 0 holds register data; buffer data joins from the RAM register there.
    logic [RD_LAT-1:0]             pv_q;
    logic                          sel_q;
    logic [RD_LAT-1:0][DATA_W-1:0] pd_q;
    logic [RD_LAT-1:0][DATA_W-1:0] res_c;

    always_comb begin
        res_c    = pd_q;
        res_c[0] = sel_q ? ram_q : pd_q[0];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pv_q  <= '0;
            sel_q <= 1'b0;
            pd_q  <= '0;
        end else begin
            pv_q  <= RD_LAT'({pv_q, acc_rd_c});
            sel_q <= acc_rd_c & buf_hit_c;
            pd_q  <= PW'({res_c, reg_rdata_c});
        end
    end

    assign mem_readdatavalid = pv_q[RD_LAT-1];
    assign mem_readdata      = res_c[RD_LAT-1];

endmodule

// File: tb/tb_disk_dma_responder.sv
// Directed self-checking bench for disk_dma_responder.
module tb_disk_dma_responder;

    localparam int unsigned BUF_WORDS = 128;
    localparam int unsigned RD_LAT    = 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic [6:0]  buf_addr;
    logic        buf_we;
    logic        buf_re;
    logic [31:0] buf_wdata;
    logic [31:0] buf_rdata;
    logic        op_req;
    logic        op_write;
    logic        op_device;
    logic [31:0] op_lba;
    logic        op_done;
    logic        op_error;
    logic        disk_op_read;
    logic        disk_op_write;
    logic        disk_op_device;

    always #5 clk_sys = ~clk_sys;

    disk_dma_responder #(
        .BUF_WORDS (BUF_WORDS),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk_sys           (clk_sys),
        .reset             (reset),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_byteenable    (mem_byteenable),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .buf_addr          (buf_addr),
        .buf_we            (buf_we),
        .buf_re            (buf_re),
        .buf_wdata         (buf_wdata),
        .buf_rdata         (buf_rdata),
        .op_req            (op_req),
        .op_write          (op_write),
        .op_device         (op_device),
        .op_lba            (op_lba),
        .op_done           (op_done),
        .op_error          (op_error),
        .disk_op_read      (disk_op_read),
        .disk_op_write     (disk_op_write),
        .disk_op_device    (disk_op_device)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          accc[$];
    int          acca[$];
    int          rvc[$];
    logic [31:0] rvd[$];
    logic [31:0] mdl [BUF_WORDS];

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Log read acceptances and returned strobes with their cycle numbers.
    always @(negedge clk_sys) begin
        if (mem_read && !mem_write && !mem_waitrequest) begin
            accc.push_back(cyc);
            acca.push_back(int'(mem_address[8:2]));
        end
        if (mem_readdatavalid) begin
            rvc.push_back(cyc);
            rvd.push_back(mem_readdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_q();
        accc.delete();
        acca.delete();
        rvc.delete();
        rvd.delete();
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk_sys);
        while (mem_waitrequest && n < 50) begin
            n++;
            @(negedge clk_sys);
        end
        if (mem_waitrequest) chk("accept_timeout", 32'(mem_waitrequest), 32'h0);
        step();
    endtask

    task automatic wait_rv(input int n);
        for (int i = 0; i < 20 && rvd.size() < n; i++) @(posedge clk_sys);
        #1;
    endtask

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        mem_address    = a;
        mem_writedata  = d;
        mem_byteenable = be;
        mem_write      = 1'b1;
        wait_accept();
        mem_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        clear_q();
        mem_address = a;
        mem_read    = 1'b1;
        wait_accept();
        mem_read = 1'b0;
        wait_rv(1);
        chk({tag, "_vld"}, 32'(rvd.size()), 32'd1);
        if (rvd.size() > 0 && accc.size() > 0) begin
            chk(tag, rvd[0], exp);
            chk({tag, "_lat"}, 32'(rvc[0] - accc[0]), 32'(RD_LAT));
        end
    endtask

    task automatic do_op(input logic w, input logic d, input logic [31:0] lba);
        op_write  = w;
        op_device = d;
        op_lba    = lba;
        op_req    = 1'b1;
        step();
        op_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_writedata = '0; mem_byteenable = 4'hF;
        buf_addr = '0; buf_we = 1'b0; buf_re = 1'b0; buf_wdata = '0;
        op_req = 1'b0; op_write = 1'b0; op_device = 1'b0; op_lba = '0;

        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_wait",  32'(mem_waitrequest),   32'd1);
        chk("rst_rdv",   32'(mem_readdatavalid), 32'd0);
        chk("rst_rdata", mem_readdata,           32'h0);
        chk("rst_brd",   buf_rdata,              32'h0);
        chk("rst_done",  32'(op_done),           32'd0);
        chk("rst_err",   32'(op_error),          32'd0);
        chk("rst_dor",   32'(disk_op_read),      32'd0);
        chk("rst_dow",   32'(disk_op_write),     32'd0);
        chk("rst_dev",   32'(disk_op_device),    32'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("wait_post_rst1", 32'(mem_waitrequest), 32'd1);
        step();
        @(negedge clk_sys);
        chk("wait_post_rst2", 32'(mem_waitrequest), 32'd0);
        step();
        rd_chk("status_rst", 32'h200, 32'h0);

        // Buffer burst write then back-to-back reads.
        mem_write = 1'b1;
        mem_byteenable = 4'hF;
        for (int i = 0; i < 128; i++) begin
            mem_address   = 32'(i * 4);
            mem_writedata = 32'(i) * 32'h01010101;
            mdl[i]        = 32'(i) * 32'h01010101;
            wait_accept();
        end
        mem_write = 1'b0;
        clear_q();
        mem_read = 1'b1;
        for (int i = 0; i < 128; i++) begin
            mem_address = 32'(i * 4);
            wait_accept();
        end
        mem_read = 1'b0;
        wait_rv(128);
        repeat (3) step();
        chk("burst_acc_cnt", 32'(accc.size()), 32'd128);
        chk("burst_rv_cnt",  32'(rvd.size()),  32'd128);
        if (accc.size() == 128) chk("burst_gapless", 32'(accc[127] - accc[0]), 32'd127);
        for (int i = 0; i < 128 && i < rvd.size() && i < accc.size(); i++) begin
            chk("burst_lat",  32'(rvc[i] - accc[i]), 32'(RD_LAT));
            chk("burst_data", rvd[i], mdl[acca[i]]);
        end

        // Internal port collides with a buffer read for three cycles.
        clear_q();
        buf_addr = 7'd5;
        buf_re = 1'b1;
        mem_address = 32'h1C;
        mem_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sys);
            chk("coll_wait", 32'(mem_waitrequest), 32'd1);
            step();
            chk("coll_brd", buf_rdata, 32'h05050505);
            if (k == 2) buf_re = 1'b0;
        end
        wait_accept();
        mem_read = 1'b0;
        wait_rv(1);
        chk("coll_acc_cnt", 32'(accc.size()), 32'd1);
        if (rvd.size() > 0) chk("coll_rd", rvd[0], 32'h07070707);

        // Internal write visible to the bridge.
        buf_addr = 7'd30; buf_wdata = 32'h13572468; buf_we = 1'b1;
        step();
        buf_we = 1'b0; buf_re = 1'b1;
        step();
        buf_re = 1'b0;
        chk("buf_rdback", buf_rdata, 32'h13572468);
        rd_chk("mem_sees_buf", 32'h78, 32'h13572468);

        // Disk read operation completed with ok.
        do_op(1'b0, 1'b1, 32'h1234);
        chk("rdop_dor", 32'(disk_op_read),   32'd1);
        chk("rdop_dow", 32'(disk_op_write),  32'd0);
        chk("rdop_dev", 32'(disk_op_device), 32'd1);
        rd_chk("rdop_lba",    32'h204, 32'h1234);
        rd_chk("rdop_status", 32'h200, 32'h6);
        mem_wr(32'h208, 32'h1, 4'hF);
        chk("rdop_dor_drop", 32'(disk_op_read), 32'd0);
        chk("rdop_done",     32'(op_done),      32'd1);
        chk("rdop_err",      32'(op_error),     32'd0);
        step();
        chk("rdop_done_1cy", 32'(op_done), 32'd0);
        rd_chk("rdop_status_idle", 32'h200, 32'h2);

        // Disk write op: ignored op_req, empty RESULT, then error.
        do_op(1'b1, 1'b0, 32'hCAFE0001);
        chk("wrop_dow", 32'(disk_op_write), 32'd1);
        chk("wrop_dor", 32'(disk_op_read),  32'd0);
        do_op(1'b0, 1'b1, 32'h55);
        chk("wrop_2nd_req_dow", 32'(disk_op_write), 32'd1);
        chk("wrop_2nd_req_dor", 32'(disk_op_read),  32'd0);
        rd_chk("wrop_lba", 32'h204, 32'hCAFE0001);
        mem_wr(32'h208, 32'h0, 4'hF);
        chk("wrop_res0_done", 32'(op_done), 32'd0);
        rd_chk("wrop_status", 32'h200, 32'h5);
        mem_wr(32'h208, 32'h2, 4'hF);
        chk("wrop_done",     32'(op_done),       32'd1);
        chk("wrop_err",      32'(op_error),      32'd1);
        chk("wrop_dow_drop", 32'(disk_op_write), 32'd0);
        step();
        chk("wrop_done_1cy", 32'(op_done),  32'd0);
        chk("wrop_err_held", 32'(op_error), 32'd1);
        mem_wr(32'h208, 32'h1, 4'hF);
        chk("idle_res_done", 32'(op_done),  32'd0);
        chk("idle_res_err",  32'(op_error), 32'd1);

        // Both result bits set: error wins.
        do_op(1'b0, 1'b0, 32'h7);
        chk("op_err_clear", 32'(op_error), 32'd0);
        mem_wr(32'h208, 32'h3, 4'hF);
        chk("both_done", 32'(op_done),  32'd1);
        chk("both_err",  32'(op_error), 32'd1);
        step();

        // Byte enables, upper address bits and register-space writes.
        mem_wr(32'h50, 32'h0, 4'hF);
        mem_wr(32'h50, 32'hAABBCCDD, 4'b0101);
        rd_chk("be_merge", 32'h50, 32'h00BB00DD);
        rd_chk("upper_addr_ignored", 32'hFFFFF450, 32'h00BB00DD);
        mem_wr(32'h200, 32'hDEADBEEF, 4'hF);
        mem_wr(32'h3FC, 32'hDEADBEEF, 4'hF);
        rd_chk("no_alias_w0", 32'h0, 32'h0);
        rd_chk("unmapped_rd", 32'h3FC, 32'h0);
        rd_chk("result_rd",   32'h208, 32'h0);

        // Reset in the middle of an operation with a read in flight.
        do_op(1'b0, 1'b1, 32'h99);
        chk("mid_dor", 32'(disk_op_read), 32'd1);
        clear_q();
        mem_address = 32'h0;
        mem_read = 1'b1;
        wait_accept();
        mem_read = 1'b0;
        reset = 1'b1;
        step();
        chk("mid_rst_dor",  32'(disk_op_read),    32'd0);
        chk("mid_rst_wait", 32'(mem_waitrequest), 32'd1);
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mid_rst_no_done", 32'(op_done), 32'd0);
            step();
        end
        chk("mid_rst_no_rv", 32'(rvd.size()), 32'd0);
        rd_chk("status_after_rst", 32'h200, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
